// File: rtl/note_pkg.sv
// Shared definitions for the note channel scheduler: channel sizes, FSM
// encoding and the key rotation used to transpose a note per requester.
package note_pkg;

  localparam int NREQ   = 5;
  localparam int NOTE_W = 27;
  localparam int IDX_W  = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Rotate left; the amount is reduced mod NOTE_W so any step product is legal.
  function automatic logic [NOTE_W-1:0] rotl(input logic [NOTE_W-1:0] x,
                                             input int amt);
    logic [2*NOTE_W-1:0] dbl;
    dbl = {x, x} << (amt % NOTE_W);
    return dbl[2*NOTE_W-1:NOTE_W];
  endfunction

endpackage

// File: rtl/note_scheduler_rr_arbiter.sv
// Combinational arbiter: fixed lowest-index priority or round-robin starting
// one past the last winner. Kept stateless so other channels can share it.
module rr_arbiter
  import note_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    if (!mode) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[IDX_W'(i)]) begin
          winner = IDX_W'(i);
          valid  = 1'b1;
        end
      end
    end else begin
      // Walk offsets from far to near so the nearest set bit after ptr is kept.
      for (int k = NREQ; k >= 1; k--) begin
        idx = (int'(ptr) + k) % NREQ;
        if (req[IDX_W'(idx)]) begin
          winner = IDX_W'(idx);
          valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Shares one note output between the player buttons: synchronize, edge-detect,
// arbitrate, then hold the granted (transposed) note and insert a silent gap.
//
// state | meaning
// IDLE  | output silent, arbitrating over pending each clock
// PLAY  | granted note driven, counting down HOLD_CYCLES
// GAP   | output silent, counting down GAP_CYCLES before next arbitration
module note_scheduler
  import note_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000,
  parameter int GAP_CYCLES  = 5000,
  parameter int STEP        = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] key,
  input  logic [NREQ-1:0]   btn,
  input  logic              sw1,
  output logic [NOTE_W-1:0] note,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [NREQ-1:0]   pending
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [NREQ-1:0]   sync1_q, sync2_q, prev_q;
  logic [NREQ-1:0]   edge_det;
  logic [NREQ-1:0]   pending_q, pending_d, clr;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  arb_win;
  logic              arb_valid;

  assign edge_det  = sync2_q & ~prev_q;
  // A fresh edge on the requester being granted re-posts it immediately.
  assign pending_d = (pending_q & ~clr) | edge_det;
  assign busy_d    = (state_d != ST_IDLE);

  rr_arbiter u_arb (
    .req    (pending_q),
    .ptr    (rr_ptr_q),
    .mode   (sw1),
    .winner (arb_win),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    clr      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d  = NREQ'(1) << arb_win;
          note_d   = rotl(key, STEP * int'(arb_win));
          clr      = NREQ'(1) << arb_win;
          cnt_d    = CNT_W'(HOLD_CYCLES - 1);
          rr_ptr_d = arb_win;
          state_d  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (cnt_q == '0) begin
          note_d  = '0;
          grant_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        note_d  = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      note_q    <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= IDX_W'(NREQ - 1);
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      note_q    <= note_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  assign note    = note_q;
  assign grant   = grant_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Shares the single 27-bit note output channel between the five player buttons.
- Each button is a requester. A rising edge posts a pending request.
- An arbiter grants one request at a time. The granted note is held for HOLD_CYCLES, then the output is silent for GAP_CYCLES.
- The block sits between the raw button/switch inputs and the note datapath. It sequences what the top level drives on note.

Parameters:
- NREQ, 5: number of requesters (buttons).
- NOTE_W, 27: note/key vector width.
- HOLD_CYCLES, 50000: clocks a granted note stays on the output; must be >= 1.
- GAP_CYCLES, 5000: silent clocks after each note; 0 means no gap state.
- STEP, 2: transpose step. Requester i rotates key left by (STEP*i) mod NOTE_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- key  in  NOTE_W  current key mask; sampled only at the grant instant
- btn  in  NREQ  raw asynchronous buttons, bit i = requester i
- sw1  in  1  arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin
- note  out  NOTE_W  registered note output; 0 = silence
- grant  out  NREQ  registered one-hot owner of note; 0 when not in PLAY
- busy  out  1  high in PLAY or GAP
- pending  out  NREQ  registered pending-request vector

Behaviour:
- Reset (reset=0, async): note=0, grant=0, busy=0, pending=0, all synchronizer and edge flops cleared, state=IDLE, counter=0, rr_ptr=NREQ-1.
- Input conditioning: btn passes through a 2-flop synchronizer per bit, then a rising-edge detect (sync & ~prev).
- Pending bits:
  - pending[i] sets on a detected edge.
  - pending[i] clears on the cycle requester i is granted.
  - An edge on i in the same cycle i is granted leaves pending[i]=1 (set wins).
  - Extra edges while pending are absorbed; there is no counting.
- Arbitration is combinational over pending, used only in IDLE:
  - sw1=0: the lowest set index wins.
  - sw1=1: search starts at (rr_ptr+1) mod NREQ and wraps; first set bit wins.
  - rr_ptr updates to the winner on each grant, in both modes.
  - sw1 changes take effect at the next arbitration only.
- State machine:
  - IDLE: if pending != 0, register grant=onehot(w) and note=rotl(key, STEP*w mod NOTE_W); clear pending[w]; counter=HOLD_CYCLES-1; go to PLAY.
  - PLAY: note and grant held stable; counter decrements each clock. When counter==0: note=0, grant=0.
    - If GAP_CYCLES>0: go to GAP with counter=GAP_CYCLES-1.
    - Else: return to IDLE.
  - GAP: note=0; counter decrements; at 0 go to IDLE.
  - Requests arriving in PLAY or GAP stay pending and are never lost.
- Latency:
  - btn first sampled high at edge k: pending visible after edge k+2; grant/note visible after edge k+3 if IDLE.
  - Note is on the output for exactly HOLD_CYCLES clocks.
  - The next grant comes GAP_CYCLES+1 clocks after note drops (one IDLE arbitration cycle).
- busy = (state != IDLE), registered alongside state.
- Counter width is clog2(max(HOLD_CYCLES, GAP_CYCLES)+1); no wrap is possible.
- Rotation: rotl by 0 is identity; the amount is reduced mod NOTE_W, so key bit b appears at bit (b+STEP*i) mod NOTE_W.
- Reset mid-PLAY: output goes silent immediately and pending requests are discarded.

Decomposition:
- Shared package note_pkg: NOTE_W, NREQ, state encoding (IDLE=0, PLAY=1, GAP=2), and a rotl function.
- One sub-module: rr_arbiter, with inputs req[NREQ], ptr, mode and outputs winner index and valid. It is combinational so it can be reused for future shared channels.
- Synchronizer and edge detect stay inline.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, STEP=2):
- Reset, then btn=00001 with key=27'h1: pending[0] after edge 3, note=27'h1 and grant=00001 after edge 4, held 4 clocks, then note=0 for 2 clocks, busy low.
- Single requester, transpose check: btn[4] pulse with key=27'h1 -> note=27'h100 (rotation 8). With key=27'h4000000 and btn[1] -> note=27'h2 (wraparound).
- btn=11111 simultaneous with sw1=0 -> grants 00001, 00010, 00100, 01000, 10000 in order, each separated by 4 PLAY + 2 GAP + 1 IDLE clocks.
- sw1=1, btn[0] and btn[1] re-pulsed continuously -> grants alternate 00001/00010; requester 0 is never granted twice in a row.
- Edge on btn[2] in the same cycle requester 2 is granted -> pending[2] stays 1, and requester 2 is granted again after the gap.
- Assert reset=0 during PLAY with pending=01010 -> note, grant, pending and busy are all 0 immediately (asynchronously); after release, no grant occurs without a new edge.
